io_control_unit: RTL and testbench

//   Moore control sequencer driving the datapath bus for the fetch cycle (T0-T2) and the

---
 rtl/io_control_unit_pkg.sv | 62 ++++++
 rtl/io_control_unit_if.sv | 31 +++
 rtl/io_control_unit_decode.sv | 32 +++
 rtl/io_control_unit.sv | 151 +++++++++++++++
 tb/tb_io_control_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/io_control_unit_pkg.sv
// Package cpu_ctrl_pkg: shared definitions for the I/O control sequencer.
//   - state_e   : 4-bit sequencer state encoding
//   - OPC_*     : 5-bit opcodes handled by this unit (in, out, nop, halt)
//   - OP_NONE   : ALU operation code meaning "no ALU activity"
//   - RC_/LD_/SC_ bit indices into reg_ctl, ld_ctl and src_ctl
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_HALT = 4'd5
    } state_e;

    localparam logic [4:0] OPC_IN   = 5'b10110;
    localparam logic [4:0] OPC_OUT  = 5'b10111;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    localparam logic [4:0] OP_NONE  = 5'b00000;

    localparam int RC_W = 7;
    localparam int LD_W = 13;
    localparam int SC_W = 8;

    // reg_ctl = {Gra,Grb,Grc,Rin,Rout,BAout,CON_in}
    localparam int RC_GRA    = 6;
    localparam int RC_GRB    = 5;
    localparam int RC_GRC    = 4;
    localparam int RC_RIN    = 3;
    localparam int RC_ROUT   = 2;
    localparam int RC_BAOUT  = 1;
    localparam int RC_CONIN  = 0;

    // ld_ctl = {MARin,Zlowin,Zhighin,PCin,MDRin,IRin,Yin,LOin,HIin,OutPortin,IncPC,read,write}
    localparam int LD_MARIN  = 12;
    localparam int LD_ZLOWIN = 11;
    localparam int LD_ZHIIN  = 10;
    localparam int LD_PCIN   = 9;
    localparam int LD_MDRIN  = 8;
    localparam int LD_IRIN   = 7;
    localparam int LD_YIN    = 6;
    localparam int LD_LOIN   = 5;
    localparam int LD_HIIN   = 4;
    localparam int LD_OUTPIN = 3;
    localparam int LD_INCPC  = 2;
    localparam int LD_READ   = 1;
    localparam int LD_WRITE  = 0;

    // src_ctl = {HIout,LOout,ZHIout,ZLOout,PCout,MDRout,Inportout,Cout}
    localparam int SC_HIOUT  = 7;
    localparam int SC_LOOUT  = 6;
    localparam int SC_ZHIOUT = 5;
    localparam int SC_ZLOOUT = 4;
    localparam int SC_PCOUT  = 3;
    localparam int SC_MDROUT = 2;
    localparam int SC_INPOUT = 1;
    localparam int SC_COUT   = 0;

endpackage

// File: rtl/io_control_unit_if.sv
// Interface io_control_unit_if: control-unit <-> datapath bus signals.
//   ir, in_valid, out_ready               : datapath/port inputs to the sequencer
//   reg_ctl, ld_ctl, src_ctl, operation   : bus strobes produced by the sequencer
//   run, illegal_op, io_timeout           : status outputs
// Modports: master = control unit (drives strobes), slave = datapath side.
interface io_control_unit_if
    import cpu_ctrl_pkg::*;
#(
    parameter int IR_W = 32
);
    logic [IR_W-1:0] ir;
    logic            in_valid;
    logic            out_ready;
    logic [RC_W-1:0] reg_ctl;
    logic [LD_W-1:0] ld_ctl;
    logic [SC_W-1:0] src_ctl;
    logic [4:0]      operation;
    logic            run;
    logic            illegal_op;
    logic            io_timeout;

    modport master (
        input  ir, in_valid, out_ready,
        output reg_ctl, ld_ctl, src_ctl, operation, run, illegal_op, io_timeout
    );

    modport slave (
        output ir, in_valid, out_ready,
        input  reg_ctl, ld_ctl, src_ctl, operation, run, illegal_op, io_timeout
    );
endinterface

// File: rtl/io_control_unit_decode.sv
// Module io_opcode_decode: combinational opcode classifier for the T3 step.
//   ir_i          : current IR contents; opcode is the top 5 bits
//   is_in_o       : opcode is in
//   is_out_o      : opcode is out
//   is_nop_o      : opcode is nop
//   is_halt_o     : opcode is halt
//   is_illegal_o  : opcode is none of the above
module io_opcode_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int IR_W = 32
) (
    input  logic [IR_W-1:0] ir_i,
    output logic            is_in_o,
    output logic            is_out_o,
    output logic            is_nop_o,
    output logic            is_halt_o,
    output logic            is_illegal_o
);
    logic [4:0] opc;
    logic       unused_ir;

    assign opc       = ir_i[IR_W-1 -: 5];
    // Operand fields belong to later instruction classes.
    assign unused_ir = ^ir_i[IR_W-6:0];

    assign is_in_o      = (opc == OPC_IN);
    assign is_out_o     = (opc == OPC_OUT);
    assign is_nop_o     = (opc == OPC_NOP);
    assign is_halt_o    = (opc == OPC_HALT);
    assign is_illegal_o = ~(is_in_o | is_out_o | is_nop_o | is_halt_o);
endmodule

// File: rtl/io_control_unit.sv
// Module io_control_unit: Moore control sequencer for fetch (T0-T2) and the
// I/O execute step (T3) of in, out, nop and halt.
//   clock : system clock, rising edge
//   clear : asynchronous active-high reset (state -> RST, all outputs 0)
//   bus   : io_control_unit_if.master (ir/in_valid/out_ready in; strobes and status out)
// Optional feature macro: IO_HANDSHAKE_EN
//   defined   : T3 of in/out waits for in_valid/out_ready, bounded by TIMEOUT
//               wait cycles, after which io_timeout pulses and the step is abandoned.
//   undefined : T3 is always one cycle, handshake inputs ignored, io_timeout = 0.
module io_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int IR_W    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              clear,
    io_control_unit_if.master bus
);
    state_e state_q;

    logic is_in, is_out, is_nop, is_halt, is_illegal;

    io_opcode_decode #(.IR_W(IR_W)) u_dec (
        .ir_i         (bus.ir),
        .is_in_o      (is_in),
        .is_out_o     (is_out),
        .is_nop_o     (is_nop),
        .is_halt_o    (is_halt),
        .is_illegal_o (is_illegal)
    );

    // in_go/out_go: the I/O strobes may fire this cycle.
    // hs_expired: the handshake wait has run out in this cycle.
    logic in_go, out_go, hs_wait, hs_expired;

`ifdef IO_HANDSHAKE_EN
    localparam logic [7:0] TMO = TIMEOUT[7:0];
    logic [7:0] wait_cnt_q;

    assign in_go      = bus.in_valid;
    assign out_go     = bus.out_ready;
    assign hs_wait    = (is_in & ~bus.in_valid) | (is_out & ~bus.out_ready);
    assign hs_expired = hs_wait & (wait_cnt_q == TMO);
`else
    logic unused_hs;

    assign in_go      = 1'b1;
    assign out_go     = 1'b1;
    assign hs_wait    = 1'b0;
    assign hs_expired = 1'b0;
    assign unused_hs  = bus.in_valid ^ bus.out_ready ^ is_nop;
`endif

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= ST_RST;
`ifdef IO_HANDSHAKE_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_RST: state_q <= ST_T0;
                ST_T0:  state_q <= ST_T1;
                ST_T1:  state_q <= ST_T2;
                ST_T2: begin
                    state_q <= ST_T3;
`ifdef IO_HANDSHAKE_EN
                    wait_cnt_q <= '0;
`endif
                end
                ST_T3: begin
                    if (is_halt) begin
                        state_q <= ST_HALT;
                    end else if (hs_wait && !hs_expired) begin
                        // Hold in T3 while the port is not ready.
`ifdef IO_HANDSHAKE_EN
                        wait_cnt_q <= wait_cnt_q + 8'd1;
`endif
                        state_q <= ST_T3;
                    end else begin
                        state_q <= ST_T0;
                    end
                end
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_RST;
            endcase
        end
    end

    // Output decode: pure function of state (plus ir/handshake in T3), so the
    // async clear forces every strobe low through state_q = RST.
    logic [RC_W-1:0] reg_c;
    logic [LD_W-1:0] ld_c;
    logic [SC_W-1:0] src_c;
    logic            run_c, ill_c, tmo_c;

    always_comb begin
        reg_c = '0;
        ld_c  = '0;
        src_c = '0;
        run_c = 1'b0;
        ill_c = 1'b0;
        tmo_c = 1'b0;
        case (state_q)
            ST_T0: begin
                run_c             = 1'b1;
                src_c[SC_PCOUT]   = 1'b1;
                ld_c[LD_MARIN]    = 1'b1;
                ld_c[LD_INCPC]    = 1'b1;
                ld_c[LD_ZLOWIN]   = 1'b1;
            end
            ST_T1: begin
                run_c             = 1'b1;
                src_c[SC_ZLOOUT]  = 1'b1;
                ld_c[LD_PCIN]     = 1'b1;
                ld_c[LD_MDRIN]    = 1'b1;
                ld_c[LD_READ]     = 1'b1;
            end
            ST_T2: begin
                run_c             = 1'b1;
                src_c[SC_MDROUT]  = 1'b1;
                ld_c[LD_IRIN]     = 1'b1;
            end
            ST_T3: begin
                run_c = 1'b1;
                if (is_in && in_go) begin
                    reg_c[RC_GRA]    = 1'b1;
                    reg_c[RC_RIN]    = 1'b1;
                    src_c[SC_INPOUT] = 1'b1;
                end
                if (is_out && out_go) begin
                    reg_c[RC_GRA]    = 1'b1;
                    reg_c[RC_ROUT]   = 1'b1;
                    ld_c[LD_OUTPIN]  = 1'b1;
                end
                ill_c = is_illegal;
                tmo_c = hs_expired;
            end
            default: ;
        endcase
    end

    assign bus.reg_ctl    = reg_c;
    assign bus.ld_ctl     = ld_c;
    assign bus.src_ctl    = src_c;
    assign bus.operation  = OP_NONE;
    assign bus.run        = run_c;
    assign bus.illegal_op = ill_c;
    assign bus.io_timeout = tmo_c;
endmodule

// File: tb/tb_io_control_unit.sv
module tb_io_control_unit;
    localparam int TIMEOUT = 255;

    // Observed output bundle: {reg_ctl, ld_ctl, src_ctl, operation, run, illegal_op, io_timeout}
    typedef struct packed {
        logic [6:0]  r;
        logic [12:0] l;
        logic [7:0]  s;
        logic [4:0]  op;
        logic        run;
        logic        ill;
        logic        tmo;
    } obs_t;

    // Expected strobe patterns, written from the signal lists bit by bit.
    localparam obs_t E_ZERO = '0;
    localparam obs_t E_T0   = {7'b0000000, 13'b1100000000100, 8'b00001000, 5'b0, 3'b100};
    localparam obs_t E_T1   = {7'b0000000, 13'b0001100000010, 8'b00010000, 5'b0, 3'b100};
    localparam obs_t E_T2   = {7'b0000000, 13'b0000010000000, 8'b00000100, 5'b0, 3'b100};
    localparam obs_t E_IN   = {7'b1001000, 13'b0000000000000, 8'b00000010, 5'b0, 3'b100};
    localparam obs_t E_OUT  = {7'b1000100, 13'b0000000001000, 8'b00000000, 5'b0, 3'b100};
    localparam obs_t E_RUN  = {7'b0000000, 13'b0000000000000, 8'b00000000, 5'b0, 3'b100};
    localparam obs_t E_ILL  = {7'b0000000, 13'b0000000000000, 8'b00000000, 5'b0, 3'b110};
    localparam obs_t E_TMO  = {7'b0000000, 13'b0000000000000, 8'b00000000, 5'b0, 3'b101};

    logic clock = 1'b0;
    logic clear = 1'b1;
    int   checks = 0;
    int   failures = 0;

    obs_t  exp_q[$];
    string tag_q[$];

    always #5 clock = ~clock;

    io_control_unit_if #(.IR_W(32)) bus ();

    io_control_unit #(.IR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    function automatic obs_t sample();
        return {bus.reg_ctl, bus.ld_ctl, bus.src_ctl, bus.operation,
                bus.run, bus.illegal_op, bus.io_timeout};
    endfunction

    // Queue one cycle's expectation, then advance to just after the next edge.
    task automatic step(input obs_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
    endtask

    // Reference model of one instruction: fetch then execute.
    // dly = cycle index within T3 at which the port becomes ready (<0: never).
    task automatic instr(input logic [31:0] w, input int dly);
        logic [4:0] opc;
        opc = w[31:27];
        bus.ir = w;
        step(E_T0, "T0");
        step(E_T1, "T1");
        step(E_T2, "T2");
        if (opc == 5'b10110 || opc == 5'b10111) begin
`ifdef IO_HANDSHAKE_EN
            for (int k = 0; k <= TIMEOUT; k++) begin
                logic rdy;
                rdy = (dly >= 0) && (k >= dly);
                if (opc == 5'b10110) begin
                    bus.in_valid = rdy;  bus.out_ready = 1'($urandom);
                end else begin
                    bus.out_ready = rdy; bus.in_valid = 1'($urandom);
                end
                if (rdy) begin
                    step((opc == 5'b10110) ? E_IN : E_OUT, "T3_io");
                    break;
                end else if (k == TIMEOUT) begin
                    step(E_TMO, "T3_timeout");
                end else begin
                    step(E_RUN, "T3_wait");
                end
            end
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b0;
`else
            bus.in_valid  = 1'($urandom);
            bus.out_ready = 1'($urandom);
            if (dly < -100) $display("unreachable");
            step((opc == 5'b10110) ? E_IN : E_OUT, "T3_io");
`endif
        end else if (opc == 5'b11010 || opc == 5'b11011) begin
            step(E_RUN, "T3_nop_halt");
        end else begin
            step(E_ILL, "T3_illegal");
        end
    endtask

    // Monitor: compares every sampled cycle against the scoreboard head.
    initial begin
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                obs_t e, a;
                string t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = sample();
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL %s t=%0t: got %h expected %h", t, $time, a, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t a;
        bus.ir = 32'h0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        // Held in reset: everything 0.
        @(posedge clock); #1;
        step(E_ZERO, "reset_held");
        step(E_ZERO, "reset_held");
        clear = 1'b0;
        step(E_ZERO, "rst_state");

        // Directed cases.
        instr(32'hB180_0000, 3);    // in r3
        instr(32'hB900_0000, 2);    // out r2
        instr(32'h0000_0000, 0);    // illegal
        instr(32'hD000_0000, 0);    // nop
        instr(32'hB180_0000, 0);

`ifdef IO_HANDSHAKE_EN
        instr(32'hB180_0000, -1);   // in_valid never rises: timeout
        instr(32'hB900_0000, -1);
`endif

        // Clear asserted mid-T1.
        bus.ir = 32'hB180_0000;
        step(E_T0, "T0_pre_clear");
        exp_q.push_back(E_T1);
        tag_q.push_back("T1_pre_clear");
        @(negedge clock); #1;
        clear = 1'b1;
        #1;
        a = sample();
        checks++;
        if (a !== E_ZERO) begin
            failures++;
            $display("FAIL async_clear: got %h expected %h", a, E_ZERO);
        end
        @(posedge clock); #1;
        step(E_ZERO, "clear_held");
        clear = 1'b0;
        step(E_ZERO, "rst_after_clear");
        instr(32'hB900_0000, 1);

        // Randomized instruction stream.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] w;
            logic [4:0]  opc;
            int sel;
            sel = $urandom_range(0, 3);
            w = $urandom;
            case (sel)
                0: opc = 5'b10110;
                1: opc = 5'b10111;
                2: opc = 5'b11010;
                default: begin
                    opc = 5'($urandom);
                    while (opc == 5'b10110 || opc == 5'b10111 ||
                           opc == 5'b11010 || opc == 5'b11011)
                        opc = 5'($urandom);
                end
            endcase
            w[31:27] = opc;
            instr(w, $urandom_range(0, 5));
        end

        // Halt: run drops and stays low until a clear pulse.
        instr(32'hD800_0000, 0);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid  = 1'($urandom);
            bus.out_ready = 1'($urandom);
            step(E_ZERO, "halt_idle");
        end
        clear = 1'b1;
        step(E_ZERO, "halt_clear");
        clear = 1'b0;
        step(E_ZERO, "rst_after_halt");
        instr(32'hB180_0000, 0);

        @(negedge clock); #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
